// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state enum, defaults and fetch-entry type for fetch_sequencer
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int          FETCH_WIDTH  = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry FIFO holding fetched {pc, instruction} pairs for decode
module fetch_skid_buffer #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] e0;
    logic [DW-1:0] e1;

    assign head = e0;

    // e0 is always the head; a pop shifts e1 forward so head stays registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-memory sequencer feeding decode
// Optional misaligned-redirect fault: FETCH_ALIGN_CHECK_EN
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int               PC_STEP  = DEF_PC_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    output logic             fetch_fault
);

    fetch_state_t       state;
    logic               inflight;
    logic [WIDTH-1:0]   inflight_pc;
    logic               fault;
    logic [1:0]         count;
    logic [2*WIDTH-1:0] head;
    logic [2:0]         occ_next;
    logic               pop;
    logic               push;
    logic               redirect_take;
    logic               bad_target;
    logic               issue;
    logic [WIDTH-1:0]   target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign bad_target = |redirect_pc[1:0];
`else
    assign target     = redirect_pc & ~WIDTH'(3);
    assign bad_target = 1'b0;
`endif

    assign redirect_take = redirect_valid && (state != ST_HALT);
    assign inst_valid    = (count != 2'd0) && (state != ST_HALT);
    assign pop           = inst_valid && inst_ready;
    assign push          = inflight && !redirect_take;

    // Buffer slots committed after this edge; keeping it <= 1 before issuing means the
    // response landing next edge always finds room.
    assign occ_next = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
    assign issue    = (state == ST_RUN) && !redirect_take && (occ_next <= 3'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            imem_addr   <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fault       <= 1'b0;
        end else if (redirect_take) begin
            inflight <= 1'b0;
            if (bad_target) begin
                state <= ST_HALT;
                fault <= 1'b1;
            end else begin
                imem_addr <= target;
            end
        end else begin
            if (state == ST_IDLE && start) state <= ST_RUN;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= imem_addr;
                imem_addr   <= imem_addr + WIDTH'(PC_STEP);
            end
        end
    end

    fetch_skid_buffer #(.DW(2*WIDTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_take),
        .din   ({inflight_pc, imem_data}),
        .head  (head),
        .count (count)
    );

    assign inst_pc     = head[2*WIDTH-1:WIDTH];
    assign inst_data   = head[WIDTH-1:0];
    assign fetch_fault = fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with a stream-level reference model
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] salt  = 32'h0;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    // synchronous instruction memory: word for the address sampled at an edge appears after it
    always @(posedge clk) imem_data <= mem_word(imem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic start_fetch(input logic rdy);
        inst_ready = rdy; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #3;
        n_vec++; if (imem_addr !== DEF_RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h exp %h", imem_addr, DEF_RESET_PC); end
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
        n_vec++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", inst_data); end
        n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h exp 0", inst_pc); end
        n_vec++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b exp 0", fetch_fault); end
        do_reset();
    endtask

    task automatic test_startup();
        do_reset();
        salt = 32'h0;
        inst_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL startup_e0_valid: got %b exp 0", inst_valid); end
        cyc();
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL startup_e1_valid: got %b exp 0", inst_valid); end
        cyc();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL startup_valid[%0d]: got %b exp 1", k, inst_valid); end
            n_vec++; if (inst_pc !== DEF_RESET_PC + 32'(4*k)) begin n_err++; $display("FAIL startup_pc[%0d]: got %h exp %h", k, inst_pc, DEF_RESET_PC + 32'(4*k)); end
            n_vec++; if (inst_data !== 32'(k)) begin n_err++; $display("FAIL startup_data[%0d]: got %h exp %h", k, inst_data, 32'(k)); end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start_fetch(1'b0);
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h exp v=1 pc=0", k, inst_valid, inst_pc); end
            n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_addr[%0d]: got %h exp 8", k, imem_addr); end
            cyc();
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k)) begin n_err++; $display("FAIL bp_resume[%0d]: got v=%b pc=%h exp pc=%h", k, inst_valid, inst_pc, 32'(4*k)); end
            cyc();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        start_fetch(1'b1);
        cyc();
        cyc();
        n_vec++; if (inst_pc !== 32'h8) begin n_err++; $display("FAIL redir_pre_pc: got %h exp 8", inst_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap0: got %b exp 0", inst_valid); end
        cyc();
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap1: got %b exp 0", inst_valid); end
        cyc();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin n_err++; $display("FAIL redir_target: got v=%b pc=%h exp pc=40", inst_valid, inst_pc); end
        n_vec++; if (inst_data !== mem_word(32'h40)) begin n_err++; $display("FAIL redir_data: got %h exp %h", inst_data, mem_word(32'h40)); end
        cyc();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h44) begin n_err++; $display("FAIL redir_next: got v=%b pc=%h exp pc=44", inst_valid, inst_pc); end
    endtask

    task automatic test_misaligned();
        do_reset();
        start_fetch(1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0) begin n_err++; $display("FAIL misalign_halt[%0d]: got f=%b v=%b exp f=1 v=0", k, fetch_fault, inst_valid); end
            cyc();
        end
`else
        cyc();
        cyc();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin n_err++; $display("FAIL misalign_force: got v=%b pc=%h exp pc=40", inst_valid, inst_pc); end
        n_vec++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL misalign_fault: got %b exp 0", fetch_fault); end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        start_fetch(1'b1);
        exp_pc = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc[%0d]: got v=%b pc=%h exp %h", k, inst_valid, inst_pc, exp_pc); end
            n_vec++; if (inst_data !== mem_word(exp_pc)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h exp %h", k, inst_data, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            cyc();
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        start_fetch(1'b0);
        repeat (3) cyc();
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b exp 0", inst_valid); end
        n_vec++; if (imem_addr !== DEF_RESET_PC) begin n_err++; $display("FAIL midrst_addr: got %h exp %h", imem_addr, DEF_RESET_PC); end
        cyc();
        reset = 1'b1; inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_idle[%0d]: got %b exp 0", k, inst_valid); end
        end
        start_fetch(1'b1);
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== DEF_RESET_PC) begin n_err++; $display("FAIL midrst_restart: got v=%b pc=%h exp pc=%h", inst_valid, inst_pc, DEF_RESET_PC); end
    endtask

    task automatic test_random();
        logic [31:0]  exp_pc;
        logic [31:0]  tgt;
        logic         rdy;
        logic         redir;
        logic         hold;
        fetch_entry_t prev;
        int           pen;
        int           hs;
        do_reset();
        salt = $urandom;
        exp_pc = DEF_RESET_PC;
        hold = 1'b0; pen = 0; hs = 0; prev = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (pen > 0) begin
                n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rnd_penalty c=%0d: got %b exp 0", c, inst_valid); end
                pen--;
            end
            if (hold) begin
                n_vec++; if (inst_valid !== 1'b1 || inst_pc !== prev.pc || inst_data !== prev.inst) begin n_err++; $display("FAIL rnd_hold c=%0d: got v=%b pc=%h d=%h exp pc=%h d=%h", c, inst_valid, inst_pc, inst_data, prev.pc, prev.inst); end
            end
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            tgt   = $urandom & 32'hFFFF_FFFC;
            inst_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
            if (inst_valid && rdy) begin
                n_vec++; if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin n_err++; $display("FAIL rnd_xfer c=%0d: got pc=%h d=%h exp pc=%h d=%h", c, inst_pc, inst_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            hold = inst_valid && !rdy && !redir;
            prev.pc = inst_pc; prev.inst = inst_data;
            if (redir) begin
                exp_pc = tgt;
                pen = 2;
            end
            cyc();
        end
        redirect_valid = 1'b0;
        n_vec++; if (hs < 300) begin n_err++; $display("FAIL rnd_throughput: got %0d transfers exp >= 300", hs); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
